// File: rtl/gol_pkg.sv
// Shared constants and enums for the Game-of-Life grid RAM arbiter.
package gol_pkg;

    localparam int unsigned GOL_ADDR_W = 16;
    localparam int unsigned GOL_DATA_W = 4;

    // Owner tag carried alongside each RAM command to route read data back.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_ENG  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/gol_clear_seq.sv
// Grid clear sequencer: walks every address once, ascending, while busy.
module gol_clear_seq #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              done_c
);

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // The final address is being issued this cycle.
    assign done_c = busy_q && (addr_q == {ADDR_W{1'b1}});
    assign busy   = busy_q;
    assign addr   = addr_q;

    // Next busy flag and address counter.
    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
                addr_d = '0;
            end
        end else if (done_c) begin
            busy_d = 1'b0;
            addr_d = '0;
        end else begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/gol_ram_arbiter.sv
// Shares the single-port grid RAM between display, engine and clear sequencer.
module gol_ram_arbiter
    import gol_pkg::*;
#(
    parameter int unsigned ADDR_W       = GOL_ADDR_W,
    parameter int unsigned DATA_W       = GOL_DATA_W,
    parameter int unsigned MAX_DISP_RUN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned      RUN_W   = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);

    arb_state_t        state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    owner_t            tag0_q, tag0_d;
    owner_t            tag1_q, tag1_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] eng_rdata_q, eng_rdata_d;

    logic              clr_start;
    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done_c;

    gol_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (clr_start),
        .busy   (clr_busy),
        .addr   (clr_addr),
        .done_c (clr_done_c)
    );

    assign clear_busy = clr_busy;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_din    = ram_din_q;

    // FSM next state and grant selection; the starved engine wins over display.
    always_comb begin
        state_d   = state_q;
        disp_gnt  = 1'b0;
        eng_gnt   = 1'b0;
        clr_start = 1'b0;
        if (state_q == ST_RUN) begin
            if (clear_start) begin
                state_d   = ST_CLEAR;
                clr_start = 1'b1;
            end else if (eng_req && (run_cnt_q == RUN_MAX)) begin
                eng_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end else if (eng_req) begin
                eng_gnt = 1'b1;
            end
        end else if (clr_done_c) begin
            state_d = ST_RUN;
        end
    end

    // Count display grants taken while the engine is kept waiting.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!eng_req || eng_gnt) begin
            run_cnt_d = '0;
        end else if (disp_gnt && (run_cnt_q < RUN_MAX)) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
    end

    // Build the next RAM command and its owner tag.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        tag0_d     = OWN_NONE;
        tag1_d     = tag0_q;
        if (state_q == ST_CLEAR) begin
            ram_addr_d = clr_addr;
            ram_din_d  = '0;
            ram_we_d   = 1'b1;
        end else if (disp_gnt) begin
            ram_addr_d = disp_addr;
            tag0_d     = OWN_DISP;
        end else if (eng_gnt) begin
            ram_addr_d = eng_addr;
            ram_din_d  = eng_wdata;
            ram_we_d   = eng_we;
            tag0_d     = eng_we ? OWN_NONE : OWN_ENG;
        end
    end

    // Route RAM output to the owner of the read now leaving the pipe.
    always_comb begin
        disp_rvalid  = (tag1_q == OWN_DISP);
        eng_rvalid   = (tag1_q == OWN_ENG);
        disp_rdata_d = disp_rvalid ? ram_dout : disp_rdata_q;
        eng_rdata_d  = eng_rvalid  ? ram_dout : eng_rdata_q;
        disp_rdata   = disp_rdata_d;
        eng_rdata    = eng_rdata_d;
    end

    // State, command register, tag pipe and read-data hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            run_cnt_q    <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_din_q    <= '0;
            tag0_q       <= OWN_NONE;
            tag1_q       <= OWN_NONE;
            disp_rdata_q <= '0;
            eng_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_din_q    <= ram_din_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            disp_rdata_q <= disp_rdata_d;
            eng_rdata_q  <= eng_rdata_d;
        end
    end

endmodule

// File: tb/tb_gol_ram_arbiter.sv
// Self-checking bench for gol_ram_arbiter with a behavioural grid/arbiter model.
module tb_gol_ram_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 4;
    localparam int unsigned MAXR  = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_start;
    logic          clear_busy;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    gol_ram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_DISP_RUN (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .eng_req     (eng_req),
        .eng_we      (eng_we),
        .eng_addr    (eng_addr),
        .eng_wdata   (eng_wdata),
        .eng_gnt     (eng_gnt),
        .eng_rvalid  (eng_rvalid),
        .eng_rdata   (eng_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    // Grid RAM: synchronous, one-cycle read latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram_we ? ram_din : ram[ram_addr];
    end

    // Reference model: expected grid, outstanding reads, display streak, clear progress.
    typedef struct {
        bit            eng;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rd_t           pend[$];
    int            cyc      = 0;
    int            streak   = 0;
    bit            busy_exp = 1'b0;
    int            clr_left = 0;
    bit            dut_dg, dut_eg;
    int            n_tests  = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: predict and check grants, read returns and busy, then advance.
    task automatic step(output bit dg, output bit eg);
        bit            dv, ev;
        logic [DW-1:0] dd, ed;
        @(negedge clk);
        dg = 1'b0;
        eg = 1'b0;
        if (!busy_exp && !clear_start) begin
            if (eng_req && streak == MAXR) eg = 1'b1;
            else if (disp_req)             dg = 1'b1;
            else if (eng_req)              eg = 1'b1;
        end
        dut_dg = disp_gnt;
        dut_eg = eng_gnt;
        check("disp_gnt", disp_gnt, dg);
        check("eng_gnt", eng_gnt, eg);
        check("clear_busy", clear_busy, busy_exp);
        dv = 1'b0; ev = 1'b0; dd = '0; ed = '0;
        for (int i = 0; i < pend.size(); ) begin
            if (pend[i].due == cyc) begin
                if (pend[i].eng) begin ev = 1'b1; ed = pend[i].data; end
                else             begin dv = 1'b1; dd = pend[i].data; end
                pend.delete(i);
            end else begin
                i++;
            end
        end
        check("disp_rvalid", disp_rvalid, dv);
        check("eng_rvalid", eng_rvalid, ev);
        if (dv) check("disp_rdata", disp_rdata, dd);
        if (ev) check("eng_rdata", eng_rdata, ed);
        if (dg) pend.push_back('{1'b0, ref_mem[disp_addr], cyc + 2});
        if (eg) begin
            if (eng_we) ref_mem[eng_addr] = eng_wdata;
            else        pend.push_back('{1'b1, ref_mem[eng_addr], cyc + 2});
        end
        if (!eng_req || eg)            streak = 0;
        else if (dg && streak < MAXR) streak++;
        if (busy_exp) begin
            ref_mem[DEPTH - clr_left] = '0;
            clr_left--;
            if (clr_left == 0) busy_exp = 1'b0;
        end else if (clear_start) begin
            busy_exp = 1'b1;
            clr_left = DEPTH;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit dg, eg;
        for (int i = 0; i < n; i++) step(dg, eg);
    endtask

    task automatic eng_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit dg, eg;
        eng_req = 1'b1; eng_we = we; eng_addr = a; eng_wdata = d;
        eg = 1'b0;
        for (int i = 0; i < 20 && !eg; i++) step(dg, eg);
        if (!eg) check("eng_timeout", 0, 1);
        eng_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_disp_rvalid", disp_rvalid, 0);
        check("rst_eng_rvalid", eng_rvalid, 0);
        check("rst_eng_rdata", eng_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        pend.delete();
        streak   = 0;
        busy_exp = 1'b0;
        clr_left = 0;
    endtask

    initial begin
        bit dg, eg;
        int g;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; clear_start = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
        do_reset();

        // Engine write then read-back of the same cell.
        eng_op(1'b1, 8'h10, 4'hA);
        eng_op(1'b0, 8'h10, 4'h0);
        idle(3);

        // Both requesters saturated: 8 display grants then 1 engine grant.
        disp_req = 1'b1; disp_addr = 8'h33;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 8'h10;
        for (int i = 0; i < 27; i++) begin
            step(dg, eg);
            check("t2_pattern_eng", dut_eg, (i % 9) == 8);
            check("t2_pattern_disp", dut_dg, (i % 9) != 8);
            if (eg) eng_addr = AW'($urandom);
            if (dg) disp_addr = AW'($urandom);
        end
        disp_req = 1'b0; eng_req = 1'b0;
        idle(3);

        // In-flight engine read survives a clear that starts next cycle.
        eng_op(1'b1, 8'h05, 4'h6);
        eng_op(1'b0, 8'h05, 4'h0);
        clear_start = 1'b1;
        step(dg, eg);
        clear_start = 1'b0;
        idle(DEPTH + 2);

        // Full clear with requests held; nothing granted until it ends.
        eng_op(1'b1, 8'h00, 4'hF);
        eng_op(1'b1, 8'h80, 4'hF);
        eng_op(1'b1, 8'hFF, 4'hF);
        clear_start = 1'b1;
        step(dg, eg);
        clear_start = 1'b0;
        disp_req = 1'b1; disp_addr = 8'h80;
        g = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            step(dg, eg);
            if (dg) begin disp_req = 1'b0; g++; end
        end
        check("t3_disp_after_clear", g, 1);
        eng_op(1'b0, 8'h00, 4'h0);
        eng_op(1'b0, 8'hFF, 4'h0);
        idle(3);

        // Randomised mix of display reads and engine reads/writes.
        for (int i = 0; i < 600; i++) begin
            if (!disp_req && ($urandom % 2) == 0) begin
                disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 15));
            end
            if (!eng_req && ($urandom % 3) != 0) begin
                eng_req = 1'b1; eng_we = 1'($urandom);
                eng_addr = AW'($urandom_range(0, 15)); eng_wdata = DW'($urandom);
            end
            step(dg, eg);
            if (dg) disp_req = 1'b0;
            if (eg) eng_req = 1'b0;
        end
        disp_req = 1'b0; eng_req = 1'b0;
        idle(3);

        // Reset mid-clear leaves the upper grid untouched.
        eng_op(1'b1, 8'h20, 4'h7);
        eng_op(1'b1, 8'h05, 4'h9);
        clear_start = 1'b1;
        step(dg, eg);
        clear_start = 1'b0;
        idle(8'h12);
        do_reset();
        eng_op(1'b0, 8'h20, 4'h0);
        eng_op(1'b0, 8'h05, 4'h0);
        idle(4);
        check("t5_pending_drained", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
